// File: rtl/sub_shift_rows_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_shift_rows_iter_if
// Description : Handshake and data bundle for the iterative SubBytes+ShiftRows
//               stage. The master side is the producer/consumer pair around
//               the block; the slave side is the block itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sub_shift_rows_iter_if;
  logic [0:127] In_Matrix;
  logic         In_Valid;
  logic         In_Ready;
  logic [0:127] Out_Matrix;
  logic         Out_Valid;
  logic         Out_Ready;
  logic         Busy;

  modport master (
    output In_Matrix, In_Valid, Out_Ready,
    input  In_Ready, Out_Matrix, Out_Valid, Busy
  );

  modport slave (
    input  In_Matrix, In_Valid, Out_Ready,
    output In_Ready, Out_Matrix, Out_Valid, Busy
  );
endinterface
`default_nettype wire

// File: rtl/sub_shift_rows_iter.sv
`default_nettype none
// ============================================================================
// Module      : sub_shift_rows_iter
// Description : Iterative AES SubBytes + ShiftRows. LANES bytes are
//               substituted per cycle; ShiftRows is folded into the choice
//               of source byte, so the output register is written directly
//               in ShiftRows order. Legal LANES: 1, 2, 4, 8, 16.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_shift_rows_iter #(
  parameter int LANES = 4
) (
  input wire                 clk,
  input wire                 rst,
  sub_shift_rows_iter_if.slave bus
);

  localparam int NSTEP = 16 / LANES;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  // FIPS-197 forward S-box, byte x at bits [8x:8x+7]
  localparam logic [0:2047] SBOX_TABLE = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   step_q, step_d;
  logic [0:127]    in_q, in_d;
  logic [0:127]    out_q, out_d;
  logic            in_ready;

  logic [8*LANES-1:0] lane_byte;
  logic [4*LANES-1:0] lane_dst;

  // Each lane owns one output byte of the current step; its source byte is
  // the same row taken (row) columns to the right, wrapping within the row.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] dst;
    logic [1:0] src_col;
    assign dst     = 4'(int'(step_q) * LANES + l);
    assign src_col = dst[3:2] + dst[1:0];
    assign lane_dst[4*l +: 4]  = dst;
    assign lane_byte[8*l +: 8] = sbox(in_q[{src_col, dst[1:0], 3'b000} +: 8]);
  end

  // Next-state, datapath update and ready generation
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    in_d     = in_q;
    out_d    = out_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.In_Valid) begin
          in_d    = bus.In_Matrix;
          step_d  = '0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        for (int l = 0; l < LANES; l++) begin
          out_d[{lane_dst[4*l +: 4], 3'b000} +: 8] = lane_byte[8*l +: 8];
        end
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DONE: begin
        // Ready follows Out_Ready so a new state can slip in as the
        // current result leaves, avoiding an idle cycle.
        in_ready = bus.Out_Ready;
        if (bus.Out_Ready) begin
          if (bus.In_Valid) begin
            in_d    = bus.In_Matrix;
            step_d  = '0;
            state_d = S_SUB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, step counter and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  assign bus.In_Ready   = in_ready & ~rst;
  assign bus.Out_Matrix = out_q;
  assign bus.Out_Valid  = (state_q == S_DONE);
  assign bus.Busy       = (state_q == S_SUB);

endmodule
`default_nettype wire

// File: tb/tb_sub_shift_rows_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_shift_rows_iter
// Description : Self-checking bench for sub_shift_rows_iter. Reference model
//               derives the S-box from GF(2^8) inversion plus the affine map
//               and applies ShiftRows on a 4x4 row/column matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_shift_rows_iter;

  localparam logic [0:127] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb [256];

  // Main device, LANES = 4
  sub_shift_rows_iter_if bus ();
  sub_shift_rows_iter #(.LANES(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  // Parameter sweep devices sharing one stimulus
  logic [0:127] sw_in;
  logic         sw_valid;
  logic         sw_ready;
  sub_shift_rows_iter_if bus_l1 ();
  sub_shift_rows_iter_if bus_l2 ();
  sub_shift_rows_iter_if bus_l8 ();
  sub_shift_rows_iter_if bus_l16 ();
  assign bus_l1.In_Matrix  = sw_in;  assign bus_l1.In_Valid  = sw_valid;  assign bus_l1.Out_Ready  = sw_ready;
  assign bus_l2.In_Matrix  = sw_in;  assign bus_l2.In_Valid  = sw_valid;  assign bus_l2.Out_Ready  = sw_ready;
  assign bus_l8.In_Matrix  = sw_in;  assign bus_l8.In_Valid  = sw_valid;  assign bus_l8.Out_Ready  = sw_ready;
  assign bus_l16.In_Matrix = sw_in;  assign bus_l16.In_Valid = sw_valid;  assign bus_l16.Out_Ready = sw_ready;
  sub_shift_rows_iter #(.LANES(1))  u_l1  (.clk(clk), .rst(rst), .bus(bus_l1));
  sub_shift_rows_iter #(.LANES(2))  u_l2  (.clk(clk), .rst(rst), .bus(bus_l2));
  sub_shift_rows_iter #(.LANES(8))  u_l8  (.clk(clk), .rst(rst), .bus(bus_l8));
  sub_shift_rows_iter #(.LANES(16)) u_l16 (.clk(clk), .rst(rst), .bus(bus_l16));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (v == 8'h00) inv = 8'h00;
    else repeat (254) inv = gmul(inv, v);
    s = inv ^ 8'h63;
    for (int k = 1; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
    return s;
  endfunction

  function automatic logic [0:127] ref_ssr(input logic [0:127] x);
    logic [7:0]   m [4][4];
    logic [0:127] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = x[8*(4*c+r) +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[8*(4*c+r) +: 8] = sb[m[r][(c+r)%4]];
    return y;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking and helpers ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [0:127] d);
    int n = 0;
    while (!bus.In_Ready && n < 50) begin tick(); n++; end
    if (!bus.In_Ready) chk("send_timeout", 0, 1);
    bus.In_Matrix = d;
    bus.In_Valid  = 1'b1;
    tick();
    bus.In_Valid  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!bus.Out_Valid && lat < 100);
    if (!bus.Out_Valid) chk("out_timeout", 0, 1);
  endtask

  task automatic run_one(input string tag, input logic [0:127] din, input logic [0:127] dexp);
    int lat;
    send(din);
    wait_out(lat);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_data"}, bus.Out_Matrix, dexp);
    bus.Out_Ready = 1'b1;
    tick();
    bus.Out_Ready = 1'b0;
    chk({tag, "_idle_ready"}, bus.In_Ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:127] a, b, hold;
    logic [0:127] stim [8];
    logic [0:127] exp_q [$];
    int lat, idx, got, t, last_t;
    bit pend;
    int sw_lat [4];
    logic [0:127] sw_res [4];

    for (int i = 0; i < 256; i++) sb[i] = ref_sbox(8'(i));

    rst = 1'b1;
    bus.In_Matrix = '0; bus.In_Valid = 1'b0; bus.Out_Ready = 1'b0;
    sw_in = '0; sw_valid = 1'b0; sw_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready",  bus.In_Ready,   0);
    chk("rst_out_valid", bus.Out_Valid,  0);
    chk("rst_busy",      bus.Busy,       0);
    chk("rst_out",       bus.Out_Matrix, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.In_Ready, 1);

    // Known answers and ShiftRows source mapping
    send(FIPS_IN);
    chk("fips_busy", bus.Busy, 1);
    wait_out(lat);
    chk("fips_lat",  lat, 4);
    chk("fips_data", bus.Out_Matrix, FIPS_OUT);
    bus.Out_Ready = 1'b1; tick(); bus.Out_Ready = 1'b0;
    run_one("zero", '0, {16{8'h63}});
    run_one("map53", 128'h00000000005300000000000000000000,
                     128'h63ed6363636363636363636363636363);
    for (int i = 0; i < 3; i++) begin
      a = rand128();
      run_one("rand", a, ref_ssr(a));
    end

    // Backpressure: result held, second input refused until Out_Ready
    send(FIPS_IN);
    wait_out(lat);
    b = rand128();
    hold = bus.Out_Matrix;
    chk("bp_first", hold, FIPS_OUT);
    bus.In_Matrix = b;
    bus.In_Valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", bus.Out_Matrix, FIPS_OUT);
      chk("bp_ready",  bus.In_Ready, 0);
      chk("bp_valid",  bus.Out_Valid, 1);
    end
    bus.Out_Ready = 1'b1;
    #1;
    chk("bp_comb_ready", bus.In_Ready, 1);
    tick();
    bus.Out_Ready = 1'b0;
    bus.In_Valid  = 1'b0;
    chk("bp_busy", bus.Busy, 1);
    wait_out(lat);
    chk("bp_lat",  lat, 4);
    chk("bp_data", bus.Out_Matrix, ref_ssr(b));
    bus.Out_Ready = 1'b1; tick(); bus.Out_Ready = 1'b0;

    // Streaming with both sides always willing
    for (int i = 0; i < 8; i++) stim[i] = rand128();
    idx = 0; got = 0; t = 0; last_t = -1;
    bus.Out_Ready = 1'b1;
    bus.In_Matrix = stim[0];
    bus.In_Valid  = 1'b1;
    #1;
    pend = bus.In_Ready && bus.In_Valid;
    while (got < 8 && t < 200) begin
      tick(); t++;
      if (pend) begin
        exp_q.push_back(ref_ssr(stim[idx]));
        idx++;
        if (idx < 8) bus.In_Matrix = stim[idx];
        else         bus.In_Valid  = 1'b0;
      end
      if (bus.Out_Valid) begin
        if (exp_q.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_data", bus.Out_Matrix, exp_q.pop_front());
        if (last_t >= 0) chk("stream_gap", t - last_t, 5);
        last_t = t;
        got++;
      end
      #1;
      pend = bus.In_Ready && bus.In_Valid;
    end
    if (got < 8) chk("stream_timeout", got, 8);
    bus.In_Valid = 1'b0;
    tick();
    bus.Out_Ready = 1'b0;

    // Reset during the second SUB cycle discards the pass
    send(rand128());
    tick();
    chk("mid_busy_before", bus.Busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.Out_Valid,  0);
    chk("mid_rst_busy",  bus.Busy,       0);
    chk("mid_rst_out",   bus.Out_Matrix, 0);
    chk("mid_rst_ready", bus.In_Ready,   0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_ready", bus.In_Ready, 1);
    run_one("mid_fips", FIPS_IN, FIPS_OUT);

    // Lane-count sweep: same result, latency 16/LANES
    for (int i = 0; i < 4; i++) begin sw_lat[i] = -1; sw_res[i] = '0; end
    sw_ready = 1'b1;
    sw_in    = FIPS_IN;
    sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus_l1.Out_Valid  && sw_lat[0] < 0) begin sw_lat[0] = k; sw_res[0] = bus_l1.Out_Matrix;  end
      if (bus_l2.Out_Valid  && sw_lat[1] < 0) begin sw_lat[1] = k; sw_res[1] = bus_l2.Out_Matrix;  end
      if (bus_l8.Out_Valid  && sw_lat[2] < 0) begin sw_lat[2] = k; sw_res[2] = bus_l8.Out_Matrix;  end
      if (bus_l16.Out_Valid && sw_lat[3] < 0) begin sw_lat[3] = k; sw_res[3] = bus_l16.Out_Matrix; end
    end
    chk("l1_lat",   sw_lat[0], 16);
    chk("l2_lat",   sw_lat[1], 8);
    chk("l8_lat",   sw_lat[2], 2);
    chk("l16_lat",  sw_lat[3], 1);
    chk("l1_data",  sw_res[0], FIPS_OUT);
    chk("l2_data",  sw_res[1], FIPS_OUT);
    chk("l8_data",  sw_res[2], FIPS_OUT);
    chk("l16_data", sw_res[3], FIPS_OUT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
